// File: rtl/bin_morph_pkg.sv
// Shared constants and helpers for the binary 3x3 morphology stage.
// No logic; no latency.
// No flow control.
package bin_morph_pkg;

    localparam logic MODE_DILATE = 1'b0;
    localparam logic MODE_ERODE  = 1'b1;

    // Column counter must hold 0..hdisp inclusive (hdisp is the saturation value).
    function automatic int hcnt_width(input int hdisp);
        return $clog2(hdisp + 1);
    endfunction

endpackage

// File: rtl/vip_matrix_generate_3x3_1bit.sv
// Builds a padded 3x3 1-bit window from the pixel stream using two line buffers.
// Latency: 1 clock from accepted pixel to window / delayed vsync / href.
// No backpressure: streaming input, one pixel per clock while href is high.
module vip_matrix_generate_3x3_1bit
    import bin_morph_pkg::*;
#(
    parameter logic [10:0] IMG_HDISP = 11'd640
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_vsync,
    input  logic       i_href,
    input  logic       i_bit,
    input  logic       i_pad,
    output logic       o_frame_start,
    output logic       o_vsync,
    output logic       o_href,
    output logic [8:0] o_win
);

    localparam int            HW   = hcnt_width(int'(IMG_HDISP));
    localparam int            AW   = (IMG_HDISP > 11'd1) ? $clog2(int'(IMG_HDISP)) : 1;
    localparam logic [HW-1:0] HMAX = HW'(IMG_HDISP);

    logic          r_vsync_d;
    logic          r_href_d;
    logic [HW-1:0] r_hcnt;
    logic [1:0]    r_vcnt;
    logic [8:0]    r_win;
    logic          r_lb1 [IMG_HDISP];
    logic          r_lb2 [IMG_HDISP];

    logic          w_frame_start;
    logic          w_href_fall;
    logic          w_in_range;
    logic [AW-1:0] w_idx;
    logic          w_lb1;
    logic          w_lb2;

    assign w_frame_start = i_vsync & ~r_vsync_d;
    assign w_href_fall   = r_href_d & ~i_href;
    assign w_in_range    = (r_hcnt < HMAX);
    assign w_idx         = r_hcnt[AW-1:0];

    // Rows that do not exist yet in this frame (or columns past the line end) read as pad,
    // which hides whatever an earlier frame left in the buffers.
    assign w_lb1 = (w_in_range && (r_vcnt >= 2'd1)) ? r_lb1[w_idx] : i_pad;
    assign w_lb2 = (w_in_range && (r_vcnt == 2'd2)) ? r_lb2[w_idx] : i_pad;

    // One-clock delayed copies of the sync signals, used for edge detection and as outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_d <= 1'b0;
            r_href_d  <= 1'b0;
        end else begin
            r_vsync_d <= i_vsync;
            r_href_d  <= i_href;
        end
    end

    // Column position within the current line; parks at IMG_HDISP on overlong lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt <= '0;
        end else if (!i_href) begin
            r_hcnt <= '0;
        end else if (r_hcnt != HMAX) begin
            r_hcnt <= r_hcnt + HW'(1);
        end
    end

    // Number of completed lines in this frame, capped at 2 (enough to unmask both buffers).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vcnt <= 2'd0;
        end else if (w_frame_start) begin
            r_vcnt <= 2'd0;
        end else if (w_href_fall && (r_vcnt != 2'd2)) begin
            r_vcnt <= r_vcnt + 2'd1;
        end
    end

    // Line buffers shift the current column down one row; storage is intentionally unreset.
    always_ff @(posedge clk) begin
        if (i_href && w_in_range) begin
            r_lb2[w_idx] <= r_lb1[w_idx];
            r_lb1[w_idx] <= i_bit;
        end
    end

    // Window shifts left by one column per pixel and refills with pad between lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win <= 9'd0;
        end else if (i_href) begin
            r_win <= {r_win[5:0], w_lb2, w_lb1, i_bit};
        end else begin
            r_win <= {9{i_pad}};
        end
    end

    assign o_frame_start = w_frame_start;
    assign o_vsync       = r_vsync_d;
    assign o_href        = r_href_d;
    assign o_win         = r_win;

endmodule

// File: rtl/bin_morph_3x3.sv
// Binary 3x3 dilate/erode on a vsync/href/bit stream; mode fixed per frame.
// Latency: 2 clocks for vsync, href and bit; output pixel (r,c) is centred on input (r-1,c-1).
// No backpressure: consumes and produces one pixel per clock.
module bin_morph_3x3
    import bin_morph_pkg::*;
#(
    parameter logic [10:0] IMG_HDISP = 11'd640
) (
    input  logic clk,
    input  logic rst_n,
    input  logic per_frame_vsync,
    input  logic per_frame_href,
    input  logic per_img_Bit,
    input  logic morph_mode,
    output logic post_frame_vsync,
    output logic post_frame_href,
    output logic post_img_Bit
);

    logic       r_mode_q;
    logic       w_frame_start;
    logic       w_vsync_d;
    logic       w_href_d;
    logic [8:0] w_win;
    logic       w_result;

    vip_matrix_generate_3x3_1bit #(
        .IMG_HDISP (IMG_HDISP)
    ) u_matrix (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_vsync       (per_frame_vsync),
        .i_href        (per_frame_href),
        .i_bit         (per_img_Bit),
        .i_pad         (r_mode_q),
        .o_frame_start (w_frame_start),
        .o_vsync       (w_vsync_d),
        .o_href        (w_href_d),
        .o_win         (w_win)
    );

    // Mode is captured only at frame start so a frame is never processed with mixed operators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_q <= MODE_DILATE;
        end else if (w_frame_start) begin
            r_mode_q <= morph_mode;
        end
    end

    assign w_result = (r_mode_q == MODE_ERODE) ? (&w_win) : (|w_win);

    // Second pipeline stage: reduce the window and gate the bit with the delayed href.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_img_Bit     <= 1'b0;
        end else begin
            post_frame_vsync <= w_vsync_d;
            post_frame_href  <= w_href_d;
            post_img_Bit     <= w_href_d & w_result;
        end
    end

endmodule

// File: tb/tb_bin_morph_3x3.sv
// Scoreboard bench for bin_morph_3x3 with an 8-pixel-wide line, 6-line frames.
module tb_bin_morph_3x3;

    localparam int NR = 6;
    localparam int NC = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic per_frame_vsync = 1'b0;
    logic per_frame_href = 1'b0;
    logic per_img_Bit = 1'b0;
    logic morph_mode = 1'b0;
    logic post_frame_vsync;
    logic post_frame_href;
    logic post_img_Bit;

    int errors = 0;
    int checks = 0;
    int out_idx = 0;

    bit exp_q [$];
    bit img     [NR][NC];
    bit exp_img [NR][NC];

    // Input history for the latency comparison, owned by the monitor.
    bit hv1 = 1'b0, hv2 = 1'b0, hh1 = 1'b0, hh2 = 1'b0;

    bin_morph_3x3 #(.IMG_HDISP(11'd8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_img_Bit      (per_img_Bit),
        .morph_mode       (morph_mode),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_img_Bit     (post_img_Bit)
    );

    always #5 clk = ~clk;

    // Monitor: on the falling edge, check sync latency and pop expected pixels.
    always @(negedge clk) begin
        if (!rst_n) begin
            hv1 = 1'b0; hv2 = 1'b0; hh1 = 1'b0; hh2 = 1'b0;
        end else begin
            checks++;
            if (post_frame_vsync !== hv2 || post_frame_href !== hh2) begin
                errors++;
                $display("FAIL sync_latency t=%0t: vsync/href got %b/%b expected %b/%b",
                         $time, post_frame_vsync, post_frame_href, hv2, hh2);
            end
            if (post_frame_href === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pixel_unexpected t=%0t: got output pixel, expected none", $time);
                end else begin
                    bit e;
                    e = exp_q.pop_front();
                    if (post_img_Bit !== e) begin
                        errors++;
                        $display("FAIL pixel[%0d] t=%0t: got %b expected %b",
                                 out_idx, $time, post_img_Bit, e);
                    end
                    out_idx++;
                end
            end else begin
                checks++;
                if (post_img_Bit !== 1'b0) begin
                    errors++;
                    $display("FAIL bit_gating t=%0t: got %b expected 0", $time, post_img_Bit);
                end
            end
            hv2 = hv1; hh2 = hh1;
            hv1 = per_frame_vsync; hh1 = per_frame_href;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Image is bg everywhere except one spot pixel (sr<0 means no spot).
    // Expected output is in_val inside the 3x3 region starting at (sr,sc), out_val elsewhere.
    task automatic set_case(input bit bg, input int sr, input int sc,
                            input bit in_val, input bit out_val);
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
                img[r][c] = (r == sr && c == sc) ? ~bg : bg;
                exp_img[r][c] = (sr >= 0 && r >= sr && r <= sr + 2 && c >= sc && c <= sc + 2)
                                ? in_val : out_val;
            end
        end
    endtask

    task automatic run_frame(input bit mode, input int gap, input int toggle_row);
        morph_mode = mode;
        per_frame_vsync = 1'b1;
        repeat (3) tick();
        for (int r = 0; r < NR; r++) begin
            if (r == toggle_row) morph_mode = ~mode;
            for (int c = 0; c < NC; c++) begin
                per_frame_href = 1'b1;
                per_img_Bit = img[r][c];
                exp_q.push_back(exp_img[r][c]);
                tick();
            end
            per_frame_href = 1'b0;
            per_img_Bit = 1'b0;
            repeat (gap) tick();
        end
        repeat (3) tick();
        per_frame_vsync = 1'b0;
        repeat (4) tick();
    endtask

    task automatic check_outs(input string name, input logic [2:0] want);
        logic [2:0] got;
        got = {post_frame_vsync, post_frame_href, post_img_Bit};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: vsync/href/bit got %b expected %b", name, got, want);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset_state", 3'b000);
        rst_n = 1'b1;
        repeat (3) tick();

        // Dilate, single 1 at (3,4); 1-clock line gap exercises back-to-back lines
        set_case(1'b0, 3, 4, 1'b1, 1'b0);
        run_frame(1'b0, 1, -1);

        // Erode, all ones except 0 at (3,4); borders stay 1 since pad is 1
        set_case(1'b1, 3, 4, 1'b0, 1'b1);
        run_frame(1'b1, 3, -1);

        // Frame isolation: all ones then all zeros, dilate
        set_case(1'b1, -1, 0, 1'b1, 1'b1);
        run_frame(1'b0, 2, -1);
        set_case(1'b0, -1, 0, 1'b0, 1'b0);
        run_frame(1'b0, 2, -1);

        // Mode toggled mid-frame is ignored: still dilated
        set_case(1'b0, 2, 2, 1'b1, 1'b0);
        run_frame(1'b0, 2, 1);
        // Next frame uses erode
        set_case(1'b1, 1, 1, 1'b0, 1'b1);
        run_frame(1'b1, 2, -1);

        // Async reset mid-line
        set_case(1'b1, -1, 0, 1'b1, 1'b1);
        morph_mode = 1'b0;
        per_frame_vsync = 1'b1;
        repeat (3) tick();
        for (int c = 0; c < 4; c++) begin
            per_frame_href = 1'b1;
            per_img_Bit = 1'b1;
            exp_q.push_back(1'b1);
            tick();
        end
        check_outs("pre_reset_active", 3'b111);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_reset", 3'b000);
        per_frame_vsync = 1'b0;
        per_frame_href = 1'b0;
        per_img_Bit = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        repeat (3) tick();

        // First row after reset must see pad above it
        set_case(1'b0, 0, 0, 1'b1, 1'b0);
        run_frame(1'b0, 2, -1);

        repeat (4) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected pixels never produced, expected 0", exp_q.size());
        end
        checks++;
        if (out_idx != 7 * NR * NC + 2) begin
            errors++;
            $display("FAIL pixel_count: got %0d output pixels expected %0d",
                     out_idx, 7 * NR * NC + 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bin_morph_3x3.md
Name: bin_morph_3x3

Overview:
Binary 3x3 morphology stage that sits directly downstream of the Sobel edge detector and consumes its 1-bit edge stream (vsync/href/bit).
- Dilation closes gaps in edge contours; erosion removes isolated noise.
- It builds its own 3x3 1-bit window from two internal line buffers.
- It outputs the same streaming format, so stages can be cascaded (erode, then dilate, for an opening).

Parameters:
IMG_HDISP, 11'd640, active pixels per line; sets line-buffer depth and column-counter range.

Ports:
clk  input  1  pixel clock.
rst_n  input  1  asynchronous active-low reset.
per_frame_vsync  input  1  frame-valid, high during the frame; rising edge = frame start.
per_frame_href  input  1  line-valid, high during active pixels.
per_img_Bit  input  1  binary pixel, meaningful only while href=1.
morph_mode  input  1  0 = dilate (OR), 1 = erode (AND); sampled at frame start.
post_frame_vsync  output  1  vsync delayed 2 clocks.
post_frame_href  output  1  href delayed 2 clocks.
post_img_Bit  output  1  morphology result; forced 0 when post_frame_href=0.

Behaviour:
- Reset (async, rst_n=0):
  - All registers and outputs go to 0: post_* = 0, counters = 0, window = 0, mode_q = 0.
  - Line-buffer storage is not reset; stale contents are masked by the row counter.
- Frame start (vsync 0->1, detected with a 1-clock delayed copy):
  - mode_q <= morph_mode; v_cnt <= 0.
  - morph_mode changes at any other time are ignored.
- Pad value = mode_q (0 for dilate, 1 for erode). Out-of-frame pixels never flip an output.
- Column counter h_cnt:
  - 0 while href=0; increments per href=1 pixel; saturates at IMG_HDISP.
  - Pixels with h_cnt >= IMG_HDISP are not written and read as pad.
- Row counter v_cnt: increments on each href falling edge, saturates at 2, cleared at frame start.
- Line buffers LB1 (row r-1) and LB2 (row r-2), each IMG_HDISP x 1 bit.
  - On an href=1 pixel at column h: read LB1[h] and LB2[h]; then write LB2[h] <= LB1[h] and LB1[h] <= per_img_Bit.
  - Read value masking: LB1 output is replaced by pad when v_cnt < 1; LB2 output is replaced by pad when v_cnt < 2.
- Pipeline, input pixel (r,c) accepted at cycle T:
  - T+1: the column {LB2, LB1, bit} shifts into a 3-column window register. Window now covers rows r-2..r, cols c-2..c.
  - Window columns are loaded with pad on every clock with href=0, so each line starts padded.
  - T+2: post_img_Bit = OR (mode_q=0) or AND (mode_q=1) of all 9 window bits, registered.
- Output geometry:
  - Output pixel (r,c) is centred on input (r-1,c-1), i.e. a fixed spatial offset of (1,1).
  - Output line and pixel counts equal input counts.
- Latency: exactly 2 clocks for vsync, href and bit.
- Lines beyond any nominal height: processed normally.
- Back-to-back lines with a 1-clock href gap are supported.

Decomposition:
- Shared package bin_morph_pkg:
  - MODE_DILATE = 1'b0, MODE_ERODE = 1'b1.
  - Function for h_cnt width, clog2(IMG_HDISP+1).
- One sub-module, vip_matrix_generate_3x3_1bit:
  - Contains the line buffers, h_cnt/v_cnt, padding mask and window register.
  - Outputs 9 window bits plus delayed vsync/href.
  - The top level holds mode latch, reduction and output gating.

Test Plan:
- IMG_HDISP=8, 6-line frame, dilate, single 1 at input (3,4) -> exactly 9 output ones at output rows 3..5, cols 4..6; all else 0.
- Erode, 8x6 frame of all ones except 0 at (3,4) -> zeros only at output rows 3..5, cols 4..6; all border pixels 1 (pad=1).
- Latency: 8-clock href pulses and vsync -> post_frame_href/post_frame_vsync identical waveforms shifted by 2 clocks; post_img_Bit=0 whenever post_frame_href=0.
- Frame isolation: frame A all ones, then frame B all zeros, dilate -> every frame-B output is 0 (no leakage from stale line buffers or window).
- morph_mode toggled 1 mid-frame on a dilate frame -> rest of frame still dilated; next frame eroded.
- rst_n pulsed low mid-line -> post_* go to 0 within the same clock asynchronously; next frame's row 0 sees pad above it (single 1 at (0,0) dilated gives ones only at rows 0..2, cols 0..2).
